// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, ALU, EX/MEM output register and an
// iterative unsigned multiply/divide unit that stalls upstream while it runs.
module execute_stage_md #(
    parameter int N_BITS = 32,
    parameter int N_REG  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic [3:0]        i_alu_op,
    input  logic              i_alu_src,
    input  logic              i_reg_dst,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic [N_BITS-1:0] i_rs_data,
    input  logic [N_BITS-1:0] i_rt_data,
    input  logic [N_BITS-1:0] i_imm,
    input  logic [N_REG-1:0]  i_rs,
    input  logic [N_REG-1:0]  i_rt,
    input  logic [N_REG-1:0]  i_rd,
    input  logic              i_memwb_reg_write,
    input  logic [N_REG-1:0]  i_memwb_rd,
    input  logic [N_BITS-1:0] i_memwb_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_alu_result,
    output logic [N_BITS-1:0] o_store_data,
    output logic [N_REG-1:0]  o_dest,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_zero
);
    localparam int CW = $clog2(N_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,   OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,   OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10,  OP_LUI = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;

    md_state_e state_q, state_d;

    logic              valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, zero_q;
    logic [N_BITS-1:0] result_q, store_q;
    logic [N_REG-1:0]  dest_q;
    logic [N_BITS-1:0] hi_q, lo_q, work_hi_q, work_lo_q, opnd_q;
    logic              div_q;
    logic [CW-1:0]     cnt_q;

    // Forwarding: EX/MEM result has priority over MEM/WB
    logic exm_a, exm_b, mwb_a, mwb_b;
    logic [N_BITS-1:0] op_a, fwd_b, op_b;

    assign exm_a = valid_q & reg_write_q & (dest_q != '0) & (dest_q == i_rs);
    assign exm_b = valid_q & reg_write_q & (dest_q != '0) & (dest_q == i_rt);
    assign mwb_a = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_rs);
    assign mwb_b = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_rt);

    assign op_a  = exm_a ? result_q : (mwb_a ? i_memwb_data : i_rs_data);
    assign fwd_b = exm_b ? result_q : (mwb_b ? i_memwb_data : i_rt_data);
    assign op_b  = i_alu_src ? i_imm : fwd_b;

    logic [CW-1:0]     shamt;
    logic [N_BITS-1:0] alu_res;
    assign shamt = op_a[CW-1:0];

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(N_BITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(N_BITS-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:  alu_res = op_b << (N_BITS / 2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    logic is_md, is_div, accept;
    assign is_div = (i_alu_op == OP_DIVU);
    assign is_md  = (i_alu_op == OP_MULTU) | is_div;
    assign accept = i_valid & ~i_flush & is_md;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (i_flush) state_d = S_IDLE;
                     else if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic stall, md_load, md_step, hilo_we;
    always_comb begin
        stall   = 1'b0;
        md_load = 1'b0;
        md_step = 1'b0;
        hilo_we = 1'b0;
        case (state_q)
            S_IDLE: begin stall = accept; md_load = accept; end
            S_RUN:  begin stall = 1'b1;   md_step = ~i_flush; end
            S_DONE: hilo_we = ~i_flush;
            default: ;
        endcase
    end

    assign o_stall = i_reset_n & stall;

    // MULTU: {work_hi,work_lo} starts as {0,B}, shift-add A. DIVU: work_lo
    // starts as dividend and fills with quotient bits, work_hi is remainder.
    logic [N_BITS:0]   mul_sum, div_sh;
    logic [N_BITS-1:0] div_diff, step_hi, step_lo;
    logic              div_ge;

    always_comb begin
        mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {work_hi_q, work_lo_q[N_BITS-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_diff = div_sh[N_BITS-1:0] - opnd_q;
        if (div_q) begin
            step_hi = div_ge ? div_diff : div_sh[N_BITS-1:0];
            step_lo = {work_lo_q[N_BITS-2:0], div_ge};
        end else begin
            step_hi = mul_sum[N_BITS:1];
            step_lo = {mul_sum[0], work_lo_q[N_BITS-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (md_load) begin
                work_hi_q <= '0;
                work_lo_q <= is_div ? op_a : op_b;
                opnd_q    <= is_div ? op_b : op_a;
                div_q     <= is_div;
                cnt_q     <= '0;
            end else if (md_step) begin
                work_hi_q <= step_hi;
                work_lo_q <= step_lo;
                cnt_q     <= cnt_q + 1'b1;
            end
            if (hilo_we) begin
                hi_q <= work_hi_q;
                lo_q <= work_lo_q;
            end
        end
    end

    logic [N_BITS-1:0] ex_res;
    assign ex_res = is_md ? '0 : alu_res;

    // Bubbles keep the data fields and clear only valid/control
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            result_q     <= '0;
            store_q      <= '0;
            dest_q       <= '0;
        end else if (stall | ~i_valid | i_flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= 1'b1;
            reg_write_q  <= i_reg_write  & ~is_md;
            mem_read_q   <= i_mem_read   & ~is_md;
            mem_write_q  <= i_mem_write  & ~is_md;
            mem_to_reg_q <= i_mem_to_reg & ~is_md;
            result_q     <= ex_res;
            zero_q       <= (ex_res == '0);
            store_q      <= fwd_b;
            dest_q       <= i_reg_dst ? i_rd : i_rt;
        end
    end

    assign o_valid      = valid_q;
    assign o_alu_result = result_q;
    assign o_store_data = store_q;
    assign o_dest       = dest_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_mem_to_reg = mem_to_reg_q;
    assign o_zero       = zero_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU ops, forwarding, MULTU/DIVU
// timing and results, flush abort and asynchronous reset.
module tb_execute_stage_md;
    localparam int N_BITS = 32;
    localparam int N_REG  = 5;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_valid, i_flush;
    logic [3:0]        i_alu_op;
    logic              i_alu_src, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
    logic [N_BITS-1:0] i_rs_data, i_rt_data, i_imm;
    logic [N_REG-1:0]  i_rs, i_rt, i_rd;
    logic              i_memwb_reg_write;
    logic [N_REG-1:0]  i_memwb_rd;
    logic [N_BITS-1:0] i_memwb_data;
    logic              o_stall, o_valid;
    logic [N_BITS-1:0] o_alu_result, o_store_data;
    logic [N_REG-1:0]  o_dest;
    logic              o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_zero;

    int n_chk = 0;
    int n_err = 0;

    execute_stage_md #(.N_BITS(N_BITS), .N_REG(N_REG)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_flush(i_flush),
        .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd),
        .i_memwb_data(i_memwb_data), .o_stall(o_stall), .o_valid(o_valid),
        .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_dest(o_dest),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one instruction into ID/EX
    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src);
        i_valid = 1'b1; i_flush = 1'b0; i_alu_op = op;
        i_rs = rs; i_rt = rt; i_rd = rd;
        i_rs_data = a; i_rt_data = b; i_imm = imm; i_alu_src = src;
        i_reg_dst = 1'b1; i_reg_write = 1'b1;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
    endtask

    // Single-cycle op on r10/r11 -> r12 (no forwarding hazards)
    task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src,
                       input logic [31:0] exp);
        drive(op, 5'd10, 5'd11, 5'd12, a, b, imm, src);
        step();
        chk(tag, o_alu_result, exp);
    endtask

    // Runs MULTU/DIVU to completion; checks the stall length and the retire bubble
    task automatic md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        drive(op, 5'd10, 5'd11, 5'd12, a, b, 32'd0, 1'b0);
        #1;
        cyc = 0;
        while (o_stall && cyc < 100) begin
            cyc++;
            step();
        end
        chk({tag, "_stall_cycles"}, cyc, 33);
        step();
        chk({tag, "_ret_valid"}, o_valid, 1'b1);
        chk({tag, "_ret_regwr"}, o_reg_write, 1'b0);
        chk({tag, "_ret_result"}, o_alu_result, 0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_memwb_reg_write = 1'b0; i_memwb_rd = '0; i_memwb_data = '0;
        drive(4'd12, 5'd10, 5'd11, 5'd12, 32'd3, 32'd4, 32'd0, 1'b0);
        step(); step();
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_result", o_alu_result, 0);
        chk("rst_dest", o_dest, 0);
        chk("rst_regwr", o_reg_write, 1'b0);
        i_reset_n = 1'b1;
        i_valid = 1'b0;
        step();

        drive(4'd0, 5'd5, 5'd0, 5'd9, 32'd7, 32'd0, 32'd3, 1'b1);
        step();
        chk("add_imm", o_alu_result, 10);
        chk("add_zero", o_zero, 1'b0);
        chk("add_valid", o_valid, 1'b1);
        chk("add_dest", o_dest, 9);

        // Forwarding
        drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
        step();
        chk("fwd_add_r3", o_alu_result, 3);
        drive(4'd1, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0);
        i_memwb_reg_write = 1'b1; i_memwb_rd = 5'd3; i_memwb_data = 32'd99;
        step();
        chk("fwd_sub_res", o_alu_result, 0);
        chk("fwd_sub_zero", o_zero, 1'b1);
        chk("fwd_exmem_prio", o_store_data, 3);
        drive(4'd0, 5'd7, 5'd0, 5'd6, 32'd0, 32'd0, 32'd1, 1'b1);
        i_memwb_rd = 5'd7; i_memwb_data = 32'd50;
        step();
        chk("fwd_memwb", o_alu_result, 51);
        drive(4'd0, 5'd0, 5'd0, 5'd8, 32'd5, 32'd0, 32'd1, 1'b1);
        i_memwb_rd = 5'd0; i_memwb_data = 32'd77;
        step();
        chk("fwd_r0_none", o_alu_result, 6);
        i_memwb_reg_write = 1'b0;

        alu("sub_wrap", 4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF);
        alu("slt",  4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1);
        alu("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0);
        chk("sltu_zero", o_zero, 1'b1);
        alu("sra",  4'd10, 32'd4, 32'h8000_0000, 32'd0, 1'b0, 32'hF800_0000);
        alu("srl",  4'd9,  32'd4, 32'h8000_0000, 32'd0, 1'b0, 32'h0800_0000);
        alu("sll",  4'd8,  32'd8, 32'd1, 32'd0, 1'b0, 32'h0000_0100);
        alu("lui",  4'd11, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 32'h1234_0000);
        alu("nor",  4'd5,  32'h0F0F_0F0F, 32'hF0F0_F000, 32'd0, 1'b0, 32'h0000_00F0);
        alu("xor",  4'd4,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'hF0F0_F0F0);

        md("multu", 4'd12, 32'hFFFF_FFFF, 32'd2);
        alu("multu_hi", 4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 32'd1);
        alu("multu_lo", 4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFE);

        md("divu", 4'd13, 32'd100, 32'd7);
        alu("divu_lo", 4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 32'd14);
        alu("divu_hi", 4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 32'd2);

        md("div0", 4'd13, 32'd5, 32'd0);
        alu("div0_hi", 4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 32'd5);
        alu("div0_lo", 4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);

        // Flush mid-RUN
        drive(4'd12, 5'd10, 5'd11, 5'd12, 32'd3, 32'd3, 32'd0, 1'b0);
        step();
        repeat (9) step();
        chk("flush_pre_stall", o_stall, 1'b1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        #1;
        chk("flush_stall_drop", o_stall, 1'b0);
        alu("flush_hi", 4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 32'd5);
        alu("flush_lo", 4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        drive(4'd0, 5'd10, 5'd11, 5'd12, 32'd2, 32'd3, 32'd0, 1'b0);
        i_flush = 1'b1;
        step();
        chk("flush_idle_valid", o_valid, 1'b0);
        alu("post_flush_add", 4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5);
        chk("post_flush_valid", o_valid, 1'b1);

        // Async reset during RUN
        drive(4'd12, 5'd10, 5'd11, 5'd12, 32'd6, 32'd7, 32'd0, 1'b0);
        repeat (5) step();
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_result", o_alu_result, 0);
        chk("arst_valid", o_valid, 1'b0);
        chk("arst_stall", o_stall, 1'b0);
        i_valid = 1'b0;
        step();
        i_reset_n = 1'b1;
        #1;
        chk("arst_release_stall", o_stall, 1'b0);
        step();
        chk("arst_no_stall", o_stall, 1'b0);
        alu("arst_hi", 4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        alu("arst_lo", 4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
